// File: rtl/if_fetch_queue_pkg.sv
// rtl/if_fetch_queue_pkg.sv - shared types and constants for the fetch queue
package if_fetch_queue_pkg;

  localparam int INSTR_W = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;

  // One queue entry: the instruction together with the PC it was fetched from
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Mask that clears the in-block byte offset of a fetch address
  function automatic logic [31:0] align_mask(input int fetch_width);
    return ~(32'(fetch_width * 4) - 32'd1);
  endfunction

endpackage

// File: rtl/if_fetch_queue_if.sv
// rtl/if_fetch_queue_if.sv - IM / ID side signal bundle of the fetch queue
interface if_fetch_queue_if #(
  parameter int FETCH_WIDTH = 2,
  parameter int DEPTH       = 8
);
  import if_fetch_queue_pkg::*;

  logic                           stall;
  logic                           request_alt_pc;
  logic [31:0]                    alt_pc;
  logic [31:0]                    instr_address_2im;
  logic [FETCH_WIDTH*INSTR_W-1:0] instr_fim;
  logic                           instr_fim_valid;
  logic [31:0]                    instr1_out;
  logic [31:0]                    instr_pc_out;
  logic [31:0]                    instr_pc_plus4;
  logic                           instr_valid_out;
  logic [$clog2(DEPTH+1)-1:0]     queue_count;

  // Fetch stage side
  modport master (
    input  stall, request_alt_pc, alt_pc, instr_fim, instr_fim_valid,
    output instr_address_2im, instr1_out, instr_pc_out, instr_pc_plus4,
           instr_valid_out, queue_count
  );

  // Environment side (instruction memory and ID stage)
  modport slave (
    output stall, request_alt_pc, alt_pc, instr_fim, instr_fim_valid,
    input  instr_address_2im, instr1_out, instr_pc_out, instr_pc_plus4,
           instr_valid_out, queue_count
  );

endinterface

// File: rtl/if_fetch_queue_fetch_queue.sv
// rtl/if_fetch_queue_fetch_queue.sv - circular instruction FIFO, multi-write single-read
module if_fetch_queue_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int FETCH_WIDTH = 2,
  parameter int DEPTH       = 8,
  localparam int OFFW       = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1,
  localparam int CW         = $clog2(DEPTH + 1),
  localparam int PTRW       = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           wr_en,
  input  logic [OFFW-1:0]                wr_start,
  input  fetch_entry_t [FETCH_WIDTH-1:0] wr_data,
  input  logic                           rd_en,
  output fetch_entry_t                   rd_data,
  output logic [CW-1:0]                  count
);

  fetch_entry_t    mem [DEPTH];
  logic [PTRW-1:0] head;
  logic [PTRW-1:0] tail;
  logic [CW-1:0]   wr_num;
  logic [CW-1:0]   wr_add;
  logic [CW-1:0]   rd_sub;

  // Slots below wr_start belong to a misaligned entry point and are skipped
  assign wr_num  = CW'(FETCH_WIDTH) - CW'(wr_start);
  assign wr_add  = wr_en ? wr_num : '0;
  assign rd_sub  = rd_en ? CW'(1) : '0;
  assign rd_data = mem[head];

  // Pointer and occupancy bookkeeping; flush empties the queue in one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wr_en) tail <= tail + PTRW'(wr_num);
      if (rd_en) head <= head + PTRW'(1);
      count <= count + wr_add - rd_sub;
    end
  end

  // Storage: pack the valid slots of the block contiguously starting at tail
  always_ff @(posedge clk) begin
    if (wr_en && !flush) begin
      for (int k = 0; k < FETCH_WIDTH; k++) begin
        if (k >= int'(wr_start)) begin
          mem[tail + PTRW'(k) - PTRW'(wr_start)] <= wr_data[k];
        end
      end
    end
  end

endmodule

// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - fetch stage: block fetch from IM into a queue, one instruction to ID
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int          FETCH_WIDTH = 2,
  parameter int          DEPTH       = 8,
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC
) (
  input logic              clk,
  input logic              rst,
  if_fetch_queue_if.master bus
);

  localparam int          OFFW        = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;
  localparam int          CW          = $clog2(DEPTH + 1);
  localparam logic [31:0] ALIGN_MASK  = align_mask(FETCH_WIDTH);
  localparam logic [31:0] BLOCK_BYTES = 32'(FETCH_WIDTH * 4);

  logic [31:0]                    fetch_pc;
  logic [31:0]                    block_pc;
  logic [OFFW-1:0]                start_slot;
  fetch_entry_t [FETCH_WIDTH-1:0] slots;
  fetch_entry_t                   head_entry;
  logic [CW-1:0]                  count;
  logic                           redirect;
  logic                           room;
  logic                           enq;
  logic                           deq;
  logic [31:0]                    instr_q;
  logic [31:0]                    pc_q;
  logic [31:0]                    pc_plus4_q;
  logic                           valid_q;

  assign block_pc = fetch_pc & ALIGN_MASK;
  assign redirect = bus.request_alt_pc;

  generate
    if (FETCH_WIDTH > 1) begin : g_offset
      assign start_slot = fetch_pc[OFFW+1:2];
    end else begin : g_no_offset
      assign start_slot = '0;
    end
  endgenerate

  // Room is judged on the occupancy before this cycle's dequeue
  assign room = (CW'(DEPTH) - count) >= CW'(FETCH_WIDTH);
  assign enq  = !redirect && bus.instr_fim_valid && room;
  assign deq  = !redirect && !bus.stall && (count != '0);

  // Tag each slot of the incoming block with its own PC
  always_comb begin
    slots = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      slots[k].pc    = block_pc + 32'(4 * k);
      slots[k].instr = bus.instr_fim[k*INSTR_W +: INSTR_W];
    end
  end

  if_fetch_queue_fetch_queue #(
    .FETCH_WIDTH (FETCH_WIDTH),
    .DEPTH       (DEPTH)
  ) u_queue (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect),
    .wr_en    (enq),
    .wr_start (start_slot),
    .wr_data  (slots),
    .rd_en    (deq),
    .rd_data  (head_entry),
    .count    (count)
  );

  // Fetch PC: redirect takes priority, otherwise advance only on an accepted block
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
    end else if (redirect) begin
      fetch_pc <= bus.alt_pc;
    end else if (enq) begin
      fetch_pc <= block_pc + BLOCK_BYTES;
    end
  end

  // ID output register: load on dequeue, bubble when empty or redirected, hold on stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q    <= '0;
      pc_q       <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else if (redirect) begin
      instr_q <= '0;
      valid_q <= 1'b0;
    end else if (deq) begin
      instr_q    <= head_entry.instr;
      pc_q       <= head_entry.pc;
      pc_plus4_q <= head_entry.pc + 32'd4;
      valid_q    <= 1'b1;
    end else if (!bus.stall) begin
      instr_q <= '0;
      valid_q <= 1'b0;
    end
  end

  assign bus.instr_address_2im = block_pc;
  assign bus.instr1_out        = instr_q;
  assign bus.instr_pc_out      = pc_q;
  assign bus.instr_pc_plus4    = pc_plus4_q;
  assign bus.instr_valid_out   = valid_q;
  assign bus.queue_count       = count;

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - directed bench for the fetch queue
module tb_if_fetch_queue;

  logic clk;
  logic rst;
  logic rst_b;
  int   checks = 0;
  int   errors = 0;

  if_fetch_queue_if #(.FETCH_WIDTH(2), .DEPTH(8)) bus_a ();
  if_fetch_queue_if #(.FETCH_WIDTH(4), .DEPTH(8)) bus_b ();

  if_fetch_queue #(.FETCH_WIDTH(2), .DEPTH(8)) dut_a (.clk(clk), .rst(rst),   .bus(bus_a));
  if_fetch_queue #(.FETCH_WIDTH(4), .DEPTH(8)) dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5A5_0F0F;
  endfunction

  // Instruction memory model: slot k holds the word at address + 4k
  always_comb begin
    bus_a.instr_fim = '0;
    for (int k = 0; k < 2; k++)
      bus_a.instr_fim[k*32 +: 32] = instr_of(bus_a.instr_address_2im + 32'(4 * k));
  end
  always_comb begin
    bus_b.instr_fim = '0;
    for (int k = 0; k < 4; k++)
      bus_b.instr_fim[k*32 +: 32] = instr_of(bus_b.instr_address_2im + 32'(4 * k));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic [31:0] exp_pc;
  int          got;
  int          cyc;
  logic        st;

  initial begin
    rst = 1'b1; rst_b = 1'b1;
    bus_a.stall = 1'b0; bus_a.request_alt_pc = 1'b0; bus_a.alt_pc = '0; bus_a.instr_fim_valid = 1'b1;
    bus_b.stall = 1'b1; bus_b.request_alt_pc = 1'b0; bus_b.alt_pc = '0; bus_b.instr_fim_valid = 1'b1;
    #1;
    chk("rst_instr", bus_a.instr1_out, 32'h0);
    chk("rst_pc", bus_a.instr_pc_out, 32'h0);
    chk("rst_plus4", bus_a.instr_pc_plus4, 32'h0);
    chk("rst_valid", 32'(bus_a.instr_valid_out), 32'd0);
    chk("rst_count", 32'(bus_a.queue_count), 32'd0);
    chk("rst_addr", bus_a.instr_address_2im, 32'hBFC0_0000);
    step(); step();
    rst = 1'b0;

    // Startup: first block enqueued, first output one edge later
    step();
    chk("e1_count", 32'(bus_a.queue_count), 32'd2);
    chk("e1_valid", 32'(bus_a.instr_valid_out), 32'd0);
    chk("e1_addr", bus_a.instr_address_2im, 32'hBFC0_0008);
    step();
    chk("e2_pc", bus_a.instr_pc_out, 32'hBFC0_0000);
    chk("e2_instr", bus_a.instr1_out, instr_of(32'hBFC0_0000));
    chk("e2_plus4", bus_a.instr_pc_plus4, 32'hBFC0_0004);
    chk("e2_valid", 32'(bus_a.instr_valid_out), 32'd1);
    chk("e2_count", 32'(bus_a.queue_count), 32'd3);
    step();
    chk("e3_pc", bus_a.instr_pc_out, 32'hBFC0_0004);
    chk("e3_count", 32'(bus_a.queue_count), 32'd4);
    chk("e3_addr", bus_a.instr_address_2im, 32'hBFC0_0018);

    // Long stall: outputs frozen, queue fills to DEPTH, fetch address stops
    bus_a.stall = 1'b1;
    repeat (10) step();
    chk("stall_pc", bus_a.instr_pc_out, 32'hBFC0_0004);
    chk("stall_instr", bus_a.instr1_out, instr_of(32'hBFC0_0004));
    chk("stall_valid", 32'(bus_a.instr_valid_out), 32'd1);
    chk("stall_count", 32'(bus_a.queue_count), 32'd8);
    chk("stall_addr", bus_a.instr_address_2im, 32'hBFC0_0028);

    // Release: strictly sequential PCs
    bus_a.stall = 1'b0;
    exp_pc = 32'hBFC0_0008;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("rel_pc", bus_a.instr_pc_out, exp_pc);
      chk("rel_instr", bus_a.instr1_out, instr_of(exp_pc));
      exp_pc += 32'd4;
    end
    chk("rel_count", 32'(bus_a.queue_count), 32'd6);
    chk("rel_addr", bus_a.instr_address_2im, 32'hBFC0_0050);

    // IM not valid: drain, then bubbles with the fetch address held
    bus_a.instr_fim_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("drain_pc", bus_a.instr_pc_out, exp_pc);
      exp_pc += 32'd4;
    end
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bub_valid", 32'(bus_a.instr_valid_out), 32'd0);
      chk("bub_instr", bus_a.instr1_out, 32'h0);
      chk("bub_pc_hold", bus_a.instr_pc_out, 32'hBFC0_004C);
      chk("bub_addr", bus_a.instr_address_2im, 32'hBFC0_0050);
      chk("bub_count", 32'(bus_a.queue_count), 32'd0);
    end
    bus_a.instr_fim_valid = 1'b1;
    step();
    chk("res_valid0", 32'(bus_a.instr_valid_out), 32'd0);
    chk("res_count", 32'(bus_a.queue_count), 32'd2);
    step();
    chk("res_pc0", bus_a.instr_pc_out, 32'hBFC0_0050);
    chk("res_valid1", 32'(bus_a.instr_valid_out), 32'd1);
    step();
    chk("res_pc1", bus_a.instr_pc_out, 32'hBFC0_0054);
    chk("res_count4", 32'(bus_a.queue_count), 32'd4);

    // Fill the queue, then redirect to a misaligned target while stalled
    bus_a.stall = 1'b1;
    repeat (3) step();
    chk("full_count", 32'(bus_a.queue_count), 32'd8);
    chk("full_addr", bus_a.instr_address_2im, 32'hBFC0_0078);
    bus_a.request_alt_pc = 1'b1;
    bus_a.alt_pc = 32'h0040_0104;
    step();
    chk("rd_count", 32'(bus_a.queue_count), 32'd0);
    chk("rd_valid", 32'(bus_a.instr_valid_out), 32'd0);
    chk("rd_instr", bus_a.instr1_out, 32'h0);
    chk("rd_pc_hold", bus_a.instr_pc_out, 32'hBFC0_0054);
    chk("rd_addr", bus_a.instr_address_2im, 32'h0040_0100);
    bus_a.request_alt_pc = 1'b0;
    bus_a.stall = 1'b0;
    step();
    chk("r1_count", 32'(bus_a.queue_count), 32'd1);
    chk("r1_valid", 32'(bus_a.instr_valid_out), 32'd0);
    chk("r1_addr", bus_a.instr_address_2im, 32'h0040_0108);
    step();
    chk("r2_pc", bus_a.instr_pc_out, 32'h0040_0104);
    chk("r2_instr", bus_a.instr1_out, instr_of(32'h0040_0104));
    chk("r2_plus4", bus_a.instr_pc_plus4, 32'h0040_0108);
    chk("r2_valid", 32'(bus_a.instr_valid_out), 32'd1);
    chk("r2_count", 32'(bus_a.queue_count), 32'd2);
    exp_pc = 32'h0040_0108;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("r_seq_pc", bus_a.instr_pc_out, exp_pc);
      exp_pc += 32'd4;
    end
    chk("pre_rst_count", 32'(bus_a.queue_count), 32'd5);

    // Asynchronous reset mid-stream
    bus_a.stall = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("arst_instr", bus_a.instr1_out, 32'h0);
    chk("arst_pc", bus_a.instr_pc_out, 32'h0);
    chk("arst_plus4", bus_a.instr_pc_plus4, 32'h0);
    chk("arst_valid", 32'(bus_a.instr_valid_out), 32'd0);
    chk("arst_count", 32'(bus_a.queue_count), 32'd0);
    chk("arst_addr", bus_a.instr_address_2im, 32'hBFC0_0000);
    step();
    rst = 1'b0;
    bus_a.stall = 1'b0;
    step();
    chk("post_count", 32'(bus_a.queue_count), 32'd2);
    chk("post_addr", bus_a.instr_address_2im, 32'hBFC0_0008);
    step();
    chk("post_pc", bus_a.instr_pc_out, 32'hBFC0_0000);

    // FETCH_WIDTH=4 instance: random stall and IM valid, PC stream scoreboard
    step();
    rst_b = 1'b0;
    got = 0;
    cyc = 0;
    exp_pc = 32'hBFC0_0000;
    while (got < 50 && cyc < 800) begin
      st = ($urandom_range(0, 2) == 0);
      bus_b.stall = st;
      bus_b.instr_fim_valid = ($urandom_range(0, 3) != 0);
      step();
      cyc++;
      if (!st && bus_b.instr_valid_out) begin
        chk("w4_pc", bus_b.instr_pc_out, exp_pc);
        chk("w4_instr", bus_b.instr1_out, instr_of(exp_pc));
        exp_pc += 32'd4;
        got++;
      end
    end
    chk("w4_delivered", 32'(got), 32'd50);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
